// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end
package fetch_pkg;
   typedef logic [31:0] xlen_t;
   typedef struct packed {
      xlen_t       pc;
      logic [31:0] inst;
   } fetch_entry_t;
   localparam int INST_BYTES = 4;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO with synchronous flush; a push on full is accepted when a pop happens in the same cycle
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CW-1:0]    count_o,
   output logic             empty_o,
   output logic             full_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   assign empty_o = cnt_q == '0;
   assign full_o  = cnt_q == CW'(DEPTH);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_q];
   assign count_o = cnt_q;
   // wrap pointers at DEPTH so non-power-of-two depths work
   always_comb begin
      wr_d  = do_push ? ((wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1)) : wr_q;
      rd_d  = do_pop ? ((rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1)) : rd_q;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end
   // reset and flush both empty the FIFO
   always_ff @(posedge clk) begin
      if (!reset_n || flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   // storage has no reset; slots are only read once written
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled RV32I fetch front end with a DEPTH-entry instruction queue and redirect flush
// Optional: define FETCH_QUEUE_BYPASS_EN for a zero-latency response-to-decode path when the queue is empty
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int              XLEN            = 32,
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [XLEN-1:0]       imem_req_addr,
   input  logic                  imem_resp_valid,
   output logic                  imem_resp_ready,
   input  logic [31:0]           imem_resp_data,
   input  logic                  redirect_valid,
   input  logic [XLEN-1:0]       redirect_pc,
   output logic                  deq_valid,
   input  logic                  deq_ready,
   output logic [XLEN-1:0]       deq_pc,
   output logic [31:0]           deq_inst,
   output logic [$clog2(DEPTH):0] occupancy
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = $clog2(MAX_OUTSTANDING + 1);
   xlen_t fetch_pc_q, fetch_pc_d, pend_pc;
   logic [OW-1:0] out_q, out_d, drop_q, drop_d, live;
   logic req_fire, resp_fire, keep, byp, q_push, q_pop, q_empty, q_full;
   logic p_empty, p_full;
   logic [PW-1:0] p_cnt;
   logic [$clog2(DEPTH):0] q_cnt;
   fetch_entry_t q_head, q_wdata;
   logic unused_ok;
   assign unused_ok = ^{p_cnt, p_empty, p_full};
   // credits count only requests whose responses will be kept
   assign live            = out_q - drop_q;
   assign imem_req_valid  = reset_n && (out_q < OW'(MAX_OUTSTANDING)) && (int'(q_cnt) + int'(live) < DEPTH);
   assign imem_req_addr   = fetch_pc_q;
   assign imem_resp_ready = reset_n;
   assign req_fire        = imem_req_valid && imem_req_ready;
   assign resp_fire       = imem_resp_valid && imem_resp_ready;
   assign keep            = resp_fire && drop_q == '0 && !redirect_valid;
`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp = keep && q_empty;
`else
   assign byp = 1'b0;
`endif
   assign deq_valid = reset_n && (!q_empty || byp);
   assign deq_pc    = q_empty ? pend_pc : q_head.pc;
   assign deq_inst  = q_empty ? imem_resp_data : q_head.inst;
   assign q_pop     = !q_empty && deq_ready;
   assign q_push    = keep && !(byp && deq_ready);
   assign q_wdata   = '{pc: pend_pc, inst: imem_resp_data};
   assign occupancy = reset_n ? q_cnt : '0;
   // stale responses were flushed from the PC FIFO, so only kept responses pop it
   sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_pend (
      .clk(clk), .reset_n(reset_n), .flush_i(redirect_valid),
      .push_i(req_fire), .wdata_i(fetch_pc_q), .pop_i(resp_fire && drop_q == '0),
      .rdata_o(pend_pc), .count_o(p_cnt), .empty_o(p_empty), .full_o(p_full)
   );
   sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_iq (
      .clk(clk), .reset_n(reset_n), .flush_i(redirect_valid),
      .push_i(q_push), .wdata_i(q_wdata), .pop_i(q_pop),
      .rdata_o(q_head), .count_o(q_cnt), .empty_o(q_empty), .full_o(q_full)
   );
   // fetch PC advance and outstanding/drop accounting; redirect marks every in-flight request stale
   always_comb begin
      out_d      = out_q + OW'(req_fire) - OW'(resp_fire);
      drop_d     = redirect_valid ? out_d : drop_q - OW'(resp_fire && drop_q != '0);
      fetch_pc_d = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : req_fire ? fetch_pc_q + xlen_t'(INST_BYTES) : fetch_pc_q;
   end
   // state register; reset restarts fetch at RESET_PC with nothing in flight
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_pc_q <= RESET_PC;
         out_q      <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
      end
   end
`ifndef SYNTHESIS
   // accounting invariants
   always_ff @(posedge clk) begin
      if (reset_n) begin
         assert (!(imem_resp_valid && out_q == '0));
         assert (!(q_push && q_full && !q_pop));
         assert (drop_q <= out_q);
      end
   end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table vectors, directed redirect/bypass corners and random traffic against an epoch-based model
module tb_fetch_queue;
   localparam int DEPTH = 4;
   localparam int MAXO  = 2;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic clk = 1'b0, reset_n = 1'b0;
   logic imem_req_valid, imem_req_ready = 1'b0, imem_resp_valid = 1'b0, imem_resp_ready;
   logic redirect_valid = 1'b0, deq_valid, deq_ready = 1'b0;
   logic [31:0] imem_req_addr, imem_resp_data = '0, redirect_pc = '0, deq_pc, deq_inst;
   logic [2:0] occupancy;

   fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset_n(reset_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_ready(imem_resp_ready), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc), .deq_inst(deq_inst),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0, cyc = 0;

   // memory-side view: every accepted request with its due cycle and the fetch epoch it belongs to
   typedef struct { logic [31:0] addr; int due; int ep; } req_t;
   req_t mq[$];
   int epoch = 0, occ_m = 0, live = 0, max_delay = 0;
   logic [31:0] exp_req_pc = '0, exp_deq_pc = '0;
   bit exp_rv, exp_dv, kept;
   bit drv_req_ready, drv_deq_ready, drv_redir, mem_hold;
   logic [31:0] drv_pc;

   typedef struct { bit dr; bit rv; logic [31:0] addr; bit dv; logic [31:0] pc; int occ; } vec_t;
   vec_t tbl[11];

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   // drive one cycle's inputs on the falling edge, then compare against the model
   task automatic drive_sample();
      @(negedge clk);
      reset_n = 1'b1;
      imem_req_ready = drv_req_ready;
      deq_ready = drv_deq_ready;
      redirect_valid = drv_redir;
      redirect_pc = drv_pc;
      imem_resp_valid = !mem_hold && mq.size() > 0 && mq[0].due <= cyc;
      imem_resp_data = imem_resp_valid ? mem_word(mq[0].addr) : $urandom;
      #1;
      live = 0;
      foreach (mq[i]) if (mq[i].ep == epoch) live++;
      exp_rv = mq.size() < MAXO && occ_m + live < DEPTH;
      kept = imem_resp_valid && mq[0].ep == epoch && !redirect_valid;
      exp_dv = occ_m > 0 || (BYP && kept);
      chk("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", imem_req_addr, exp_req_pc);
      chk("resp_ready", imem_resp_ready, 1);
      chk("deq_valid", deq_valid, exp_dv);
      if (exp_dv) begin
         chk("deq_pc", deq_pc, exp_deq_pc);
         chk("deq_inst", deq_inst, mem_word(exp_deq_pc));
      end
      chk("occupancy", occupancy, occ_m);
   endtask

   // advance the model by the fires of the cycle just sampled
   task automatic commit();
      bit byp_used;
      byp_used = BYP && kept && occ_m == 0 && deq_ready;
      if (exp_dv && deq_ready) exp_deq_pc += 4;
      occ_m += ((kept && !byp_used) ? 1 : 0) - ((exp_dv && deq_ready && !byp_used) ? 1 : 0);
      if (imem_resp_valid) void'(mq.pop_front());
      if (exp_rv && imem_req_ready) begin
         mq.push_back('{addr: exp_req_pc, due: cyc + 1 + int'($urandom_range(0, max_delay)), ep: epoch});
         exp_req_pc += 4;
      end
      if (redirect_valid) begin
         epoch++;
         occ_m = 0;
         exp_req_pc = redirect_pc & ~32'h3;
         exp_deq_pc = exp_req_pc;
      end
      cyc++;
   endtask

   task automatic tick();
      drive_sample();
      commit();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      imem_resp_valid = 1'b0;
      redirect_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("rst_req_valid", imem_req_valid, 0);
         chk("rst_resp_ready", imem_resp_ready, 0);
         chk("rst_deq_valid", deq_valid, 0);
         chk("rst_occupancy", occupancy, 0);
      end
      mq.delete();
      epoch++;
      occ_m = 0;
      exp_req_pc = 32'h0;
      exp_deq_pc = 32'h0;
   endtask

   task automatic wait_deq(string n, logic [31:0] pc);
      for (int i = 0; i < 50; i++) begin
         drive_sample();
         if (deq_valid) begin
            chk(n, deq_pc, pc);
            commit();
            return;
         end
         commit();
      end
      checks++;
      errors++;
      $display("FAIL %s: no deq_valid within 50 cycles, expected pc %h", n, pc);
   endtask

   initial begin
      tbl = '{
         '{0, 1, 32'h00, 0,   32'h0, 0},
         '{0, 1, 32'h04, BYP, 32'h0, 0},
         '{0, 1, 32'h08, 1,   32'h0, 1},
         '{0, 1, 32'h0C, 1,   32'h0, 2},
         '{0, 0, 32'h00, 1,   32'h0, 3},
         '{0, 0, 32'h00, 1,   32'h0, 4},
         '{0, 0, 32'h00, 1,   32'h0, 4},
         '{1, 0, 32'h00, 1,   32'h0, 4},
         '{0, 1, 32'h10, 1,   32'h4, 3},
         '{0, 0, 32'h00, 1,   32'h4, 3},
         '{0, 0, 32'h00, 1,   32'h4, 4}
      };
      drv_req_ready = 1; drv_deq_ready = 0; drv_redir = 0; drv_pc = '0; mem_hold = 0; max_delay = 0;
      do_reset();
      // zero-wait memory, decode stalled: fill to DEPTH, then pop one and refill
      foreach (tbl[i]) begin
         drv_deq_ready = tbl[i].dr;
         drive_sample();
         chk($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].rv);
         if (tbl[i].rv) chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].addr);
         chk($sformatf("tbl%0d_deq_valid", i), deq_valid, tbl[i].dv);
         if (tbl[i].dv) chk($sformatf("tbl%0d_deq_pc", i), deq_pc, tbl[i].pc);
         chk($sformatf("tbl%0d_occupancy", i), occupancy, tbl[i].occ);
         commit();
      end
      // free-running stream from reset
      do_reset();
      drv_deq_ready = 1;
      repeat (40) tick();
      // two requests in flight (0x10, 0x14), then redirect to 0x103
      do_reset();
      mem_hold = 1; drv_deq_ready = 1; drv_req_ready = 0; drv_redir = 1; drv_pc = 32'h10;
      tick();
      drv_redir = 0; drv_req_ready = 1;
      repeat (3) tick();
      drv_redir = 1; drv_pc = 32'h103;
      tick();
      drv_redir = 0;
      drive_sample();
      chk("A_next_addr", imem_req_addr, 32'h100);
      commit();
      mem_hold = 0;
      wait_deq("A_first_deq_pc", 32'h100);
      repeat (10) tick();
      // redirect while a response and a request both fire, one already outstanding
      do_reset();
      drv_req_ready = 1; drv_deq_ready = 0;
      tick();
      drv_redir = 1; drv_pc = 32'h200;
      drive_sample();
      chk("B_req_fire", imem_req_valid, 1);
      commit();
      drv_redir = 0;
      tick();
      drive_sample();
      chk("B_occ_after_drop", occupancy, 0);
      commit();
      drv_deq_ready = 1;
      wait_deq("B_first_deq_pc", 32'h200);
      // single response into an empty queue with decode ready
      do_reset();
      drv_deq_ready = 1; drv_req_ready = 0; drv_redir = 1; drv_pc = 32'h20;
      tick();
      drv_redir = 0; drv_req_ready = 1;
      tick();
      drv_req_ready = 0;
      drive_sample();
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("D_byp_deq_valid", deq_valid, 1);
      chk("D_byp_deq_pc", deq_pc, 32'h20);
      commit();
      drive_sample();
      chk("D_byp_occupancy", occupancy, 0);
      commit();
`else
      chk("D_deq_valid_same_cycle", deq_valid, 0);
      commit();
      drive_sample();
      chk("D_deq_valid_next", deq_valid, 1);
      chk("D_deq_pc_next", deq_pc, 32'h20);
      commit();
`endif
      // random traffic: 1-in-3 request ready, 0..5 cycle response delay, occasional redirects
      do_reset();
      max_delay = 5;
      for (int i = 0; i < 3000; i++) begin
         drv_req_ready = $urandom_range(0, 2) == 0;
         drv_deq_ready = $urandom_range(0, 3) != 0;
         drv_redir = (i == 1600) || (i > 1500 && $urandom_range(0, 40) == 0);
         drv_pc = (i == 1600) ? 32'hFFFF_FFF9 : $urandom;
         tick();
         if (i == 2500) do_reset();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
